// File: rtl/countdown_timer.sv
// Loadable down-counter with IDLE/RUN/PAUSE control and a one-cycle done pulse on expiry.
// Optional feature: define TIMER_AUTO_RELOAD_EN to restart from the reload value after each expiry.
module countdown_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             pause,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10
  } state_t;

  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state_r, state_s;
  logic [WIDTH-1:0] count_r, count_s;
  logic [WIDTH-1:0] reload_r, reload_s;
  logic             done_r, done_s;
  logic             busy_r;

  // Next-state logic: load beats start/expiry, which beat pause, which beats decrement.
  always_comb begin
    state_s  = state_r;
    count_s  = count_r;
    reload_s = reload_r;
    done_s   = 1'b0;
    if (load) begin
      count_s  = load_val;
      reload_s = load_val;
      state_s  = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            if (count_r != ZERO) begin
              state_s = RUN;
            end else begin
              done_s = 1'b1;
            end
          end else begin
            state_s = IDLE;
          end
        end
        RUN: begin
          if (count_r == ONE) begin
            count_s = ZERO;
            done_s  = 1'b1;
`ifdef TIMER_AUTO_RELOAD_EN
            if (reload_r == ZERO) begin
              state_s = IDLE;
            end else begin
              state_s = RUN;
            end
`else
            state_s = IDLE;
`endif
          end else if (count_r == ZERO) begin
            // Only reachable after an auto-reload expiry: refill and keep running.
`ifdef TIMER_AUTO_RELOAD_EN
            if (reload_r != ZERO) begin
              count_s = reload_r;
            end else begin
              state_s = IDLE;
            end
`else
            state_s = IDLE;
`endif
          end else if (pause) begin
            state_s = PAUSE;
          end else begin
            count_s = count_r - ONE;
          end
        end
        PAUSE: begin
          if (pause) begin
            state_s = PAUSE;
          end else begin
            state_s = RUN;
          end
        end
        default: begin
          state_s = IDLE;
        end
      endcase
    end
  end

  // State and output registers; reset clears everything without a done pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r  <= IDLE;
      count_r  <= ZERO;
      reload_r <= ZERO;
      done_r   <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      count_r  <= count_s;
      reload_r <= reload_s;
      done_r   <= done_s;
      busy_r   <= (state_s != IDLE);
    end
  end

  assign count = count_r;
  assign busy  = busy_r;
  assign done  = done_r;

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: directed scenarios plus random traffic
// compared cycle by cycle against a behavioural timer model.
module tb_countdown_timer;
  localparam int W = 4;
`ifdef TIMER_AUTO_RELOAD_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         load = 1'b0;
  logic [W-1:0] load_val = '0;
  logic         start = 1'b0;
  logic         pause = 1'b0;
  logic [W-1:0] count;
  logic         busy;
  logic         done;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model: remaining ticks, reload value, whether counting and whether frozen.
  int m_count = 0;
  int m_reload = 0;
  bit m_active = 1'b0;
  bit m_frozen = 1'b0;
  bit m_done = 1'b0;

  countdown_timer #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .load(load), .load_val(load_val),
    .start(start), .pause(pause), .count(count), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".count"}, 32'(count), 32'(m_count));
    chk({tag, ".busy"}, 32'(busy), 32'(m_active));
    chk({tag, ".done"}, 32'(done), 32'(m_done));
  endtask

  // Apply the timer rules for one rising edge to the model.
  task automatic model_edge(input bit l, input int lv, input bit s, input bit p);
    m_done = 1'b0;
    if (l) begin
      m_count = lv; m_reload = lv; m_active = 1'b0; m_frozen = 1'b0;
    end else if (!m_active) begin
      if (s && m_count == 0) m_done = 1'b1;
      else if (s) m_active = 1'b1;
    end else if (m_frozen) begin
      if (!p) m_frozen = 1'b0;
    end else if (m_count == 1) begin
      m_count = 0; m_done = 1'b1;
      if (!(AUTO && m_reload != 0)) m_active = 1'b0;
    end else if (m_count == 0) begin
      if (AUTO && m_reload != 0) m_count = m_reload;
      else m_active = 1'b0;
    end else if (p) begin
      m_frozen = 1'b1;
    end else begin
      m_count = m_count - 1;
    end
  endtask

  task automatic step(input bit l, input int lv, input bit s, input bit p, input string tag);
    @(negedge clk);
    load = l; load_val = W'(lv); start = s; pause = p;
    @(posedge clk);
    model_edge(l, lv, s, p);
    #1;
    check_all(tag);
  endtask

  initial begin
    int edges;
    bit seen;

    // Reset state
    #2 reset = 1'b0;
    #1 check_all("reset");
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    step(1'b0, 0, 1'b0, 1'b0, "post_reset_idle");

    // Load 5, start, count down and time the done pulse
    step(1'b1, 5, 1'b0, 1'b0, "load5");
    step(1'b0, 0, 1'b1, 1'b0, "start5");
    edges = 0; seen = 1'b0;
    while (!seen && edges < 20) begin
      step(1'b0, 0, 1'b0, 1'b0, "run5");
      edges++;
      seen = done;
    end
    chk("latency5", 32'(edges), 32'd5);
    step(1'b0, 0, 1'b0, 1'b0, "after5");

    // Load 6, pause three cycles once count reaches 4
    step(1'b1, 6, 1'b0, 1'b0, "load6");
    step(1'b0, 0, 1'b1, 1'b0, "start6");
    edges = 0;
    repeat (2) begin step(1'b0, 0, 1'b0, 1'b0, "run6"); edges++; end
    chk("at4", 32'(count), 32'd4);
    repeat (3) begin step(1'b0, 0, 1'b0, 1'b1, "pause6"); edges++; end
    seen = 1'b0;
    while (!seen && edges < 30) begin
      step(1'b0, 0, 1'b0, 1'b0, "resume6");
      edges++;
      seen = done;
    end
    chk("latency6", 32'(edges), 32'd10);

    // Load and start on the same edge: load wins
    step(1'b1, 3, 1'b1, 1'b0, "load_start");
    step(1'b0, 0, 1'b0, 1'b0, "hold3");
    step(1'b0, 0, 1'b1, 1'b0, "start3");
    repeat (5) step(1'b0, 0, 1'b0, 1'b0, "run3");

    // Start with count 0, then start while running
    step(1'b1, 0, 1'b0, 1'b0, "load0");
    step(1'b0, 0, 1'b1, 1'b0, "start0");
    step(1'b0, 0, 1'b0, 1'b0, "after0");
    step(1'b1, 4, 1'b0, 1'b0, "load4");
    step(1'b0, 0, 1'b1, 1'b0, "start4");
    repeat (2) step(1'b0, 0, 1'b1, 1'b0, "restart_ignored");

    // Reset mid-countdown at count 7
    step(1'b1, 9, 1'b0, 1'b0, "load9");
    step(1'b0, 0, 1'b1, 1'b0, "start9");
    repeat (2) step(1'b0, 0, 1'b0, 1'b0, "run9");
    chk("at7", 32'(count), 32'd7);
    #2 reset = 1'b0;
    m_count = 0; m_reload = 0; m_active = 1'b0; m_frozen = 1'b0; m_done = 1'b0;
    #1 check_all("midrun_reset");
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    repeat (3) step(1'b0, 0, 1'b0, 1'b0, "after_reset");

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      step(($urandom % 12) == 0, int'($urandom % 16), ($urandom % 4) == 0,
           ($urandom % 3) == 0, "random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
